buzzer_input_conditioner: RTL

Front-end stage that sits directly upstream of the buzzer/scoring controller. It takes raw asynchronous push-button/switch inputs (team buzzers A/B/C, inc, dec), synchronises and debounces each one, and produces clean levels plus single-cycle rise/fall pulses. It also latches which contending buzzer was pressed first, with a fixed tie-break, so the controller consumes one clean first-press event per round.

---
 rtl/buzzer_input_conditioner.sv | 103 ++++++++++
 1 files changed

// File: rtl/buzzer_input_conditioner.sv
// Synchronises, debounces and edge-detects raw buzzer/switch inputs, and latches
// the first contending buzzer press of a round with a lowest-index tie-break.
module buzzer_input_conditioner #(
  parameter int N_IN       = 5,
  parameter int CONTEND    = 3,
  parameter int DEB_CYCLES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] btn_in,
  input  logic            clear,
  output logic [N_IN-1:0] btn_level,
  output logic [N_IN-1:0] btn_rise,
  output logic [N_IN-1:0] btn_fall,
  output logic            first_valid,
  output logic [2:0]      first_id
);

  localparam logic [31:0] DEB_TC = 32'(DEB_CYCLES - 1);

  logic [N_IN-1:0] sync1_q, sync2_q;
  logic [N_IN-1:0] level_q, level_d;
  logic [N_IN-1:0] rise_q, rise_d;
  logic [N_IN-1:0] fall_q, fall_d;
  logic [31:0]     cnt_q [N_IN];
  logic [31:0]     cnt_d [N_IN];
  logic            first_valid_q, first_valid_d;
  logic [2:0]      first_id_q, first_id_d;
  logic            win_any;
  logic [2:0]      win_id;

  // Counter tracks consecutive cycles sync2 disagrees with the debounced level.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DEB_TC) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 32'd1;
        end
      end
    end
  end

  // Descending scan so the lowest contending index is the last (winning) write.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = CONTEND - 1; i >= 0; i--) begin
      if (rise_q[i]) begin
        win_any = 1'b1;
        win_id  = 3'(i + 1);
      end
    end
  end

  always_comb begin
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    if (clear) begin
      first_valid_d = 1'b0;
      first_id_d    = '0;
    end else if (!first_valid_q && win_any) begin
      first_valid_d = 1'b1;
      first_id_d    = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      level_q       <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= btn_in;
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign first_valid = first_valid_q;
  assign first_id    = first_id_q;

endmodule
